// File: rtl/adder_bist_ctrl.sv
// Exhaustive built-in self-test controller for a combinational adder: sweeps
// every operand pair, compares the returned sum/carry with a+b, reports results.
module adder_bist_ctrl #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] s_in,
  input  logic             cout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
  logic             seen_q, seen_d;
  logic             pass_q, pass_d;
  logic [WIDTH:0]   golden;
  logic             mismatch;

  // Golden sum is kept at WIDTH+1 bits so the carry is compared too.
  always_comb begin
    golden   = {1'b0, a_q} + {1'b0, b_q};
    mismatch = ({cout_in, s_in} != golden);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    wait_d  = wait_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    seen_d  = seen_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          seen_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        a_d     = vec_q[VW-1:WIDTH];
        b_d     = vec_q[WIDTH-1:0];
        wait_d  = CW'(SETTLE);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == CW'(1)) state_d = S_CHECK;
        else                  wait_d  = wait_q - CW'(1);
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          if (!seen_q) begin
            fa_d   = a_q;
            fb_d   = b_q;
            seen_d = 1'b1;
          end
        end
        if (vec_q == '1) begin
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + VW'(1);
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      seen_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      seen_q  <= seen_d;
      pass_q  <= pass_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Directed bench for adder_bist_ctrl: two instances (1-bit and 2-bit adders)
// driven against a behavioural adder with selectable faults.
module tb_adder_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start2;
  logic [0:0] a1, b1, s1, fa1, fb1;
  logic       c1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [1:0] a2, b2, s2, fa2, fb2;
  logic       c2, busy2, done2, pass2;
  logic [1:0] err2;
  int         fault1 = 0, fault2 = 0;
  logic [8:0] r1, r2;

  int n_vec = 0;
  int n_mis = 0;
  logic [15:0] exp_q[$];

  adder_bist_ctrl #(.WIDTH(1), .SETTLE(1), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
    .s_in(s1), .cout_in(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_a(fa1), .fail_b(fb1));

  adder_bist_ctrl #(.WIDTH(2), .SETTLE(3), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2),
    .s_in(s2), .cout_in(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_a(fa2), .fail_b(fb2));

  // mode 0 good, 1 sum stuck at 0, 2 carry inverted, 3 whole output stuck at 0
  function automatic logic [8:0] faulty(input int mode, input int w,
                                        input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = {1'b0, a} + {1'b0, b};
    case (mode)
      1: r = r & (9'(1) << w);
      2: r[w] = ~r[w];
      3: r = '0;
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    r1 = faulty(fault1, 1, {7'b0, a1}, {7'b0, b1});
    s1 = r1[0:0];
    c1 = r1[1];
    r2 = faulty(fault2, 2, {6'b0, a2}, {6'b0, b2});
    s2 = r2[1:0];
    c2 = r2[2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expected vector order and compute expected sweep results.
  task automatic expect_sweep(input int mode, input int w, input int errw,
                              output int e_err, output int e_fa, output int e_fb);
    bit seen;
    int a, b, maxe;
    logic [8:0] good, got;
    seen = 0; e_err = 0; e_fa = 0; e_fb = 0;
    maxe = (1 << errw) - 1;
    for (int v = 0; v < (1 << (2 * w)); v++) begin
      a = v >> w;
      b = v & ((1 << w) - 1);
      good = 9'(a + b);
      got  = faulty(mode, w, 8'(a), 8'(b));
      if (got !== good) begin
        if (e_err < maxe) e_err++;
        if (!seen) begin seen = 1; e_fa = a; e_fb = b; end
      end
      exp_q.push_back(16'(v));
    end
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_vec++; n_mis++;
      $error("FAIL %s: observed %0h expected <queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(obs), 32'(e));
    end
  endtask

  // Full sweep on the 1-bit instance; optionally pulse start mid-sweep.
  task automatic sweep1(input int mode, input bit poke);
    int e_err, e_fa, e_fb;
    fault1 = mode;
    expect_sweep(mode, 1, 8, e_err, e_fa, e_fb);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_start_busy", 32'(busy1), 1);
    chk("w1_start_done", 32'(done1), 0);
    chk("w1_start_err",  32'(err1), 0);
    chk("w1_start_fail", {fa1, fb1}, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (k % 3 == 1) pop_chk("w1_vec", {14'b0, a1, b1});
      if (k < 12) chk("w1_busy", 32'(busy1), 1);
      if (poke && k == 4) start1 = 1'b1;
    end
    chk("w1_done",     32'(done1), 1);
    chk("w1_idle",     32'(busy1), 0);
    chk("w1_err",      32'(err1), 32'(e_err));
    chk("w1_fail_a",   32'(fa1), 32'(e_fa));
    chk("w1_fail_b",   32'(fb1), 32'(e_fb));
    chk("w1_pass",     32'(pass1), 32'(e_err == 0));
    chk("w1_q_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e_err, e_fa, e_fb;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_outs1", {busy1, done1, pass1, err1, a1, b1, fa1, fb1}, 0);
    chk("rst_outs2", {busy2, done2, pass2, err2, a2, b2, fa2, fb2}, 0);
    @(negedge clk);
    chk("idle_hold", {busy1, done1}, 0);

    sweep1(0, 1'b0);          // good half adder
    sweep1(1, 1'b0);          // sum stuck at 0, restarted from DONE
    sweep1(2, 1'b0);          // carry inverted
    sweep1(0, 1'b1);          // mid-sweep start ignored
    repeat (2) @(negedge clk);
    chk("done_hold", {done1, pass1}, 2'b11);

    // Reset during WAIT of vector 2 (a=1,b=0)
    fault1 = 1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_vec", {a1, b1}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_abort", {busy1, done1, pass1, err1, a1, b1, fa1, fb1}, 0);
    sweep1(1, 1'b0);

    // 2-bit adder, SETTLE=3, output stuck at zero, 2-bit saturating counter
    fault2 = 3;
    expect_sweep(3, 2, 2, e_err, e_fa, e_fb);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k % 5 == 1) pop_chk("w2_vec", {12'b0, a2, b2});
      if (k < 80) chk("w2_busy", 32'(busy2), 1);
    end
    chk("w2_done",   32'(done2), 1);
    chk("w2_err",    32'(err2), 32'(e_err));
    chk("w2_fail_a", 32'(fa2), 32'(e_fa));
    chk("w2_fail_b", 32'(fb2), 32'(e_fb));
    chk("w2_pass",   32'(pass2), 0);
    chk("w2_q_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
